// File: rtl/bcd_conversion_scheduler_pkg.sv
// Shared types and helpers for the BCD conversion scheduler: FSM encoding,
// BCD digit width and index-width sizing.
package bcd_conversion_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

  localparam int BCD_DIGIT_W = 4;

  // Bits needed to index `count` items; never less than one bit.
  function automatic int index_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/bcd_conversion_scheduler_if.sv
// Start/Busy/Done link between the scheduler (master) and the shared
// sequential binary-to-BCD converter (slave).
interface bcd_conversion_scheduler_if
  import bcd_conversion_scheduler_pkg::*;
#(
  parameter int INPUT_BITS    = 16,
  parameter int OUTPUT_DIGITS = 4
);

  logic                                 ConvStart_o;
  logic [INPUT_BITS-1:0]                ConvBinary_o;
  logic                                 ConvBusy_i;
  logic                                 ConvDone_i;
  logic [OUTPUT_DIGITS*BCD_DIGIT_W-1:0] ConvBCD_i;

  modport master (
    output ConvStart_o,
    output ConvBinary_o,
    input  ConvBusy_i,
    input  ConvDone_i,
    input  ConvBCD_i
  );

  modport slave (
    input  ConvStart_o,
    input  ConvBinary_o,
    output ConvBusy_i,
    output ConvDone_i,
    output ConvBCD_i
  );

endinterface

// File: rtl/bcd_conversion_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr (wrapping), returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  always_comb begin
    logic [IDX_W:0] pos;
    grant = '0;
    index = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      // One spare bit lets ptr+i exceed N before the wrap subtraction.
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!valid && req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        index = pos[IDX_W-1:0];
      end
    end
    grant = valid ? (N'(1) << index) : '0;
  end

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// Round-robin scheduler sharing one Start/Busy/Done BCD converter between
// REQUESTERS clients. Define BCD_SCHEDULER_TIMEOUT_EN to add the WAIT timeout and Timeout_o.
module bcd_conversion_scheduler
  import bcd_conversion_scheduler_pkg::*;
#(
  parameter int REQUESTERS     = 4,
  parameter int INPUT_BITS     = 16,
  parameter int OUTPUT_DIGITS  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                            Clock,
  input  logic                                            Reset,
  input  logic [REQUESTERS-1:0]                           Request_i,
  input  logic [REQUESTERS*INPUT_BITS-1:0]                Binary_i,
  output logic [REQUESTERS-1:0]                           Done_o,
  output logic [REQUESTERS*OUTPUT_DIGITS*BCD_DIGIT_W-1:0] BCD_o,
  output logic [REQUESTERS-1:0]                           Pending_o,
  output logic                                            Busy_o,
`ifdef BCD_SCHEDULER_TIMEOUT_EN
  output logic                                            Timeout_o,
`endif
  bcd_conversion_scheduler_if.master                      conv
);

  localparam int IDX_W  = index_width(REQUESTERS);
  localparam int SLOT_W = OUTPUT_DIGITS * BCD_DIGIT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQUESTERS - 1);

  sched_state_t state_reg, state_next;

  logic [REQUESTERS-1:0] pending_reg;
  logic [REQUESTERS-1:0] done_reg;
  logic [REQUESTERS-1:0] arb_grant;
  logic [REQUESTERS-1:0] clear_mask;
  logic [IDX_W-1:0]      idx_reg;
  logic [IDX_W-1:0]      ptr_reg;
  logic [IDX_W-1:0]      arb_index;
  logic                  arb_valid;
  logic [INPUT_BITS-1:0] conv_bin_reg;
  logic [INPUT_BITS-1:0] binary_arr [REQUESTERS];
  logic [SLOT_W-1:0]     slot_reg   [REQUESTERS];

  logic take_grant;
  logic finish_ok;
  logic abandon;
  logic conv_start;
  logic busy;

  rr_arbiter #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (pending_reg),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .index (arb_index),
    .valid (arb_valid)
  );

  // Per-client operand unpacking and result slots.
  generate
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_client
      assign binary_arr[gi] = Binary_i[gi*INPUT_BITS +: INPUT_BITS];
      assign BCD_o[gi*SLOT_W +: SLOT_W] = slot_reg[gi];

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          slot_reg[gi] <= '0;
        end else if (finish_ok && (idx_reg == IDX_W'(gi))) begin
          slot_reg[gi] <= conv.ConvBCD_i;
        end
      end
    end
  endgenerate

`ifdef BCD_SCHEDULER_TIMEOUT_EN
  localparam int TMO_W = index_width(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_reg;

  // Counter is zero on the first WAIT cycle, so the abandon edge lands
  // TIMEOUT_CYCLES-1 cycles after START and Timeout_o follows one cycle later.
  assign abandon = (state_reg == ST_WAIT) && !conv.ConvDone_i &&
                   (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= (state_reg == ST_WAIT) ? tmo_cnt_reg + 1'b1 : '0;
      timeout_reg <= abandon;
    end
  end

  assign Timeout_o = timeout_reg;
`else
  assign abandon = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (take_grant) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (finish_ok || abandon) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    take_grant = 1'b0;
    finish_ok  = 1'b0;
    conv_start = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy       = 1'b0;
        take_grant = arb_valid && !conv.ConvBusy_i;
      end
      ST_START: conv_start = 1'b1;
      ST_WAIT:  finish_ok  = conv.ConvDone_i;
      default:  busy       = 1'b0;
    endcase
  end

  // A request on the index being granted this cycle wins over the clear.
  assign clear_mask = take_grant ? arb_grant : '0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_reg  <= '0;
      idx_reg      <= '0;
      ptr_reg      <= '0;
      conv_bin_reg <= '0;
      done_reg     <= '0;
    end else begin
      pending_reg <= (pending_reg & ~clear_mask) | Request_i;
      done_reg    <= finish_ok ? (REQUESTERS'(1) << idx_reg) : '0;
      if (take_grant) begin
        idx_reg      <= arb_index;
        conv_bin_reg <= binary_arr[arb_index];
      end
      if (finish_ok || abandon) begin
        ptr_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  assign Done_o            = done_reg;
  assign Pending_o         = pending_reg;
  assign Busy_o            = busy;
  assign conv.ConvStart_o  = conv_start;
  assign conv.ConvBinary_o = conv_bin_reg;

endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// Randomised bench for bcd_conversion_scheduler: a converter stub plus a
// cycle-level reference model built from the scheduling rules.
module tb_bcd_conversion_scheduler;

  localparam int R  = 4;
  localparam int IB = 16;
  localparam int OD = 4;
  localparam int SW = OD * 4;
  localparam int T  = 64;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [R-1:0]      Request_i;
  logic [R*IB-1:0]   Binary_i;
  logic [R-1:0]      Done_o;
  logic [R*SW-1:0]   BCD_o;
  logic [R-1:0]      Pending_o;
  logic              Busy_o;
`ifdef BCD_SCHEDULER_TIMEOUT_EN
  logic              Timeout_o;
`endif

  bcd_conversion_scheduler_if #(.INPUT_BITS(IB), .OUTPUT_DIGITS(OD)) conv_if ();

  bcd_conversion_scheduler #(
    .REQUESTERS     (R),
    .INPUT_BITS     (IB),
    .OUTPUT_DIGITS  (OD),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Request_i (Request_i),
    .Binary_i  (Binary_i),
    .Done_o    (Done_o),
    .BCD_o     (BCD_o),
    .Pending_o (Pending_o),
    .Busy_o    (Busy_o),
`ifdef BCD_SCHEDULER_TIMEOUT_EN
    .Timeout_o (Timeout_o),
`endif
    .conv      (conv_if)
  );

  always #5 Clock = ~Clock;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model state
  int            m_phase;   // 0 idle, 1 start, 2 wait
  int            m_idx;
  int            m_ptr;
  int            m_wait;
  bit            m_pend [R];
  logic [SW-1:0] m_slot [R];
  logic [IB-1:0] m_op;
  logic [R-1:0]  m_done;
  bit            m_tmo;

  // Client values and converter stub
  logic [IB-1:0] val [R];
  bit            sb_run, sb_busy, sb_done, sb_never, inject_done;
  int            sb_cnt, sb_tail;
  logic [IB-1:0] sb_val;
  bit            last_start;
  logic [IB-1:0] last_bin;

  int done_cnt [R];
  int glog [$];
  int start_cycles [$];
  int tmo_pulses;
  int tmo_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    else pass_cnt++;
  endtask

  function automatic logic [SW-1:0] to_bcd(input logic [IB-1:0] v);
    logic [SW-1:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < OD; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [R*SW-1:0] model_slots();
    logic [R*SW-1:0] p;
    for (int k = 0; k < R; k++) p[k*SW +: SW] = m_slot[k];
    return p;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_ptr = 0; m_wait = 0;
    m_op = '0; m_done = '0; m_tmo = 1'b0;
    for (int k = 0; k < R; k++) begin
      m_pend[k] = 1'b0;
      m_slot[k] = '0;
      done_cnt[k] = 0;
    end
    sb_run = 1'b0; sb_busy = 1'b0; sb_done = 1'b0; sb_cnt = 0; sb_tail = 0;
    inject_done = 1'b0; last_start = 1'b0; last_bin = '0;
  endtask

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_step(input logic [R-1:0] req, input bit done_in, input bit busy_in);
    bit found;
    m_done = '0;
    m_tmo  = 1'b0;
    found  = 1'b0;
    if (m_phase == 0) begin
      if (!busy_in) begin
        for (int i = 0; i < R; i++) begin
          int k;
          k = (m_ptr + i) % R;
          if (!found && m_pend[k]) begin
            found = 1'b1;
            m_idx = k;
          end
        end
        if (found) begin
          m_op = val[m_idx];
          m_pend[m_idx] = 1'b0;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_wait  = 0;
    end else begin
      if (done_in) begin
        m_slot[m_idx] = to_bcd(m_op);
        m_done[m_idx] = 1'b1;
        m_ptr   = (m_idx + 1) % R;
        m_phase = 0;
      end
`ifdef BCD_SCHEDULER_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == T - 1) begin
          m_tmo   = 1'b1;
          m_ptr   = (m_idx + 1) % R;
          m_phase = 0;
        end
      end
`endif
    end
    for (int k = 0; k < R; k++) if (req[k]) m_pend[k] = 1'b1;
  endtask

  task automatic stub_step();
    sb_done = 1'b0;
    if (last_start) begin
      if (!sb_never) begin
        sb_run  = 1'b1;
        sb_busy = 1'b1;
        sb_val  = last_bin;
        sb_cnt  = int'($urandom_range(1, 6));
        sb_tail = int'($urandom_range(0, 2));
      end
    end else if (sb_run) begin
      sb_cnt--;
      if (sb_cnt == 0) begin
        sb_run  = 1'b0;
        sb_done = 1'b1;
        sb_busy = (sb_tail > 0);
      end
    end else if (sb_busy) begin
      sb_tail--;
      if (sb_tail <= 0) sb_busy = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [R-1:0] pend_vec;
    for (int k = 0; k < R; k++) pend_vec[k] = m_pend[k];
    check("done",    64'(Done_o),               64'(m_done));
    check("bcd",     64'(BCD_o),                64'(model_slots()));
    check("pending", 64'(Pending_o),            64'(pend_vec));
    check("busy",    64'(Busy_o),               64'(m_phase != 0));
    check("start",   64'(conv_if.ConvStart_o),  64'(m_phase == 1));
    check("convbin", 64'(conv_if.ConvBinary_o), 64'(m_op));
`ifdef BCD_SCHEDULER_TIMEOUT_EN
    check("timeout", 64'(Timeout_o), 64'(m_tmo));
    if (Timeout_o) begin
      tmo_pulses++;
      tmo_cyc = cyc;
      $display("cyc %0d: timeout", cyc);
    end
`endif
    for (int k = 0; k < R; k++) begin
      if (Done_o[k]) begin
        done_cnt[k]++;
        $display("cyc %0d: slot %0d <= %h", cyc, k, BCD_o[k*SW +: SW]);
      end
    end
    if (conv_if.ConvStart_o) begin
      start_cycles.push_back(cyc);
      if (conv_if.ConvBinary_o == 16'd100)      glog.push_back(0);
      else if (conv_if.ConvBinary_o == 16'd300) glog.push_back(3);
      else                                      glog.push_back(9);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic tick(input logic [R-1:0] req);
    bit pre_done, pre_busy;
    Request_i = req;
    for (int k = 0; k < R; k++) Binary_i[k*IB +: IB] = val[k];
    conv_if.ConvDone_i = sb_done | inject_done;
    conv_if.ConvBusy_i = sb_busy;
    conv_if.ConvBCD_i  = inject_done ? 16'($urandom) : to_bcd(sb_val);
    pre_done = conv_if.ConvDone_i;
    pre_busy = conv_if.ConvBusy_i;
    @(posedge Clock);
    cyc++;
    model_step(req, pre_done, pre_busy);
    stub_step();
    inject_done = 1'b0;
    @(negedge Clock);
    compare_all();
    last_start = conv_if.ConvStart_o;
    last_bin   = conv_if.ConvBinary_o;
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0);
  endtask

  task automatic run_until_phase(input int ph, input int who, input int limit);
    int n;
    n = 0;
    while (!(m_phase == ph && (who < 0 || m_idx == who)) && n < limit) begin
      tick('0);
      n++;
    end
    check("wait_bound", 64'(n < limit), 64'(1));
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Request_i = '0;
    conv_if.ConvDone_i = 1'b0;
    conv_if.ConvBusy_i = 1'b0;
    #1;
    check("rst_done",    64'(Done_o),               64'(0));
    check("rst_bcd",     64'(BCD_o),                64'(0));
    check("rst_pending", 64'(Pending_o),            64'(0));
    check("rst_busy",    64'(Busy_o),               64'(0));
    check("rst_start",   64'(conv_if.ConvStart_o),  64'(0));
    check("rst_convbin", 64'(conv_if.ConvBinary_o), 64'(0));
`ifdef BCD_SCHEDULER_TIMEOUT_EN
    check("rst_timeout", 64'(Timeout_o), 64'(0));
`endif
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    Reset = 1'b1;
    Request_i = '0;
    Binary_i = '0;
    conv_if.ConvDone_i = 1'b0;
    conv_if.ConvBusy_i = 1'b0;
    conv_if.ConvBCD_i  = '0;
    sb_never = 1'b0;
    sb_val = '0;
    tmo_pulses = 0;
    tmo_cyc = 0;
    for (int k = 0; k < R; k++) val[k] = '0;
    @(negedge Clock);
    do_reset();
    idle(2);

    // Single request on client 0
    val[0] = 16'd1234;
    glog.delete();
    tick(4'b0001);
    idle(20);
    check("single_slot0",  64'(BCD_o[15:0]),  64'(16'h1234));
    check("single_done0",  64'(done_cnt[0]),  64'(1));
    check("single_starts", 64'(glog.size()),  64'(1));

    // All four at once
    do_reset();
    val[0] = 16'd1; val[1] = 16'd22; val[2] = 16'd333; val[3] = 16'd9999;
    tick(4'b1111);
    idle(60);
    check("all_slot0", 64'(BCD_o[15:0]),  64'(16'h0001));
    check("all_slot1", 64'(BCD_o[31:16]), 64'(16'h0022));
    check("all_slot2", 64'(BCD_o[47:32]), 64'(16'h0333));
    check("all_slot3", 64'(BCD_o[63:48]), 64'(16'h9999));
    for (int k = 0; k < R; k++) check("all_done_once", 64'(done_cnt[k]), 64'(1));

    // Merged requests, then re-request during START with a new value
    do_reset();
    val[0] = 16'd10; val[2] = 16'd500;
    tick(4'b0101);
    tick(4'b0100);
    tick(4'b0100);
    run_until_phase(1, 2, 60);
    val[2] = 16'd4321;
    tick(4'b0100);
    idle(40);
    check("merge_done0", 64'(done_cnt[0]), 64'(1));
    check("merge_done2", 64'(done_cnt[2]), 64'(2));
    check("rereq_slot2", 64'(BCD_o[47:32]), 64'(16'h4321));

    // Request landing on the grant cycle is kept
    base = done_cnt[2];
    val[2] = 16'd55;
    tick(4'b0100);
    tick(4'b0100);
    idle(40);
    check("setwins_cnt",   64'(done_cnt[2] - base), 64'(2));
    check("setwins_slot2", 64'(BCD_o[47:32]),       64'(16'h0055));

    // Reset while waiting on the converter
    val[1] = 16'd77;
    tick(4'b0010);
    run_until_phase(2, 1, 20);
    tick('0);
    do_reset();
    val[1] = 16'd4095;
    tick(4'b0010);
    idle(25);
    check("post_rst_slot1", 64'(BCD_o[31:16]), 64'(16'h4095));
    check("post_rst_done1", 64'(done_cnt[1]),  64'(1));

    // Fairness between clients 0 and 3
    do_reset();
    val[0] = 16'd100; val[3] = 16'd300;
    glog.delete();
    repeat (100) tick(4'b1001);
    idle(30);
    check("fair_count", 64'(glog.size() >= 6), 64'(1));
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check($sformatf("fair%0d", i), 64'(glog[i]), 64'((i % 2 == 1) ? 3 : 0));

    // Random traffic with spurious converter Done outside WAIT
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic [R-1:0] req;
      for (int k = 0; k < R; k++) begin
        req[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) val[k] = 16'($urandom_range(0, 9999));
      end
      inject_done = (m_phase != 2) && ($urandom_range(0, 19) == 0);
      tick(req);
    end
    idle(40);

`ifdef BCD_SCHEDULER_TIMEOUT_EN
    // Converter never answers the first operation
    do_reset();
    sb_never = 1'b1;
    val[0] = 16'd11; val[1] = 16'd22;
    start_cycles.delete();
    tmo_pulses = 0;
    tick(4'b0011);
    for (int n = 0; n < 200 && tmo_pulses == 0; n++) tick('0);
    sb_never = 1'b0;
    check("tmo_seen", 64'(tmo_pulses), 64'(1));
    if (start_cycles.size() > 0)
      check("tmo_dist", 64'(tmo_cyc - start_cycles[0]), 64'(T));
    idle(30);
    check("tmo_slot0", 64'(BCD_o[15:0]),  64'(0));
    check("tmo_done0", 64'(done_cnt[0]),  64'(0));
    check("tmo_next1", 64'(done_cnt[1]),  64'(1));
    check("tmo_slot1", 64'(BCD_o[31:16]), 64'(16'h0022));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_conversion_scheduler.md
Name: bcd_conversion_scheduler

Overview:
- Shares one sequential binary-to-BCD converter (double-dabble, Start/Busy/Done handshake) between REQUESTERS independent clients, e.g. several encoder counters feeding one display.
- Collects conversion requests, grants the converter round-robin and sequences its Start pulse.
- Captures each result into a per-requester BCD register and pulses a per-requester done flag.
- Sits between the counters and the converter instance; the display reads the BCD registers.

Parameters:
- REQUESTERS, 4, number of clients (2..8).
- INPUT_BITS, 16, binary width per client and to the converter.
- OUTPUT_DIGITS, 4, BCD digits per result.
- TIMEOUT_CYCLES, 64, WAIT-state limit; used only with the optional feature.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  reset, asynchronous, active-low.
- Request_i  in  REQUESTERS  one-cycle request pulse per client.
- Binary_i  in  REQUESTERS*INPUT_BITS  client k value in bits [k*INPUT_BITS +: INPUT_BITS].
- Done_o  out  REQUESTERS  one-cycle pulse: slot k updated.
- BCD_o  out  REQUESTERS*OUTPUT_DIGITS*4  per-client result slots, same packing as Binary_i.
- Pending_o  out  REQUESTERS  sticky pending flags.
- Busy_o  out  1  high whenever the FSM is not IDLE.
- ConvStart_o  out  1  converter start pulse.
- ConvBinary_o  out  INPUT_BITS  registered operand to the converter.
- ConvBusy_i  in  1  converter busy.
- ConvDone_i  in  1  converter done pulse.
- ConvBCD_i  in  OUTPUT_DIGITS*4  converter result.

Behaviour:
- Reset: all outputs 0, Pending 0, all slots 0, pointer 0, FSM IDLE. Reset mid-conversion discards the operation; the converter shares Reset.
- Request_i[k] sets Pending[k] at the next edge. A repeated request while pending merges into one conversion.
- FSM states:
  - IDLE: when Pending != 0 and ConvBusy_i = 0, select the first pending index searching pointer, pointer+1, ... mod REQUESTERS. At the edge: latch the index, register Binary_i[index] into ConvBinary_o, clear Pending[index], go to START. The operand is sampled at grant, not at request.
  - START: ConvStart_o = 1 for exactly this cycle, then go to WAIT.
  - WAIT: on ConvDone_i = 1, at that edge write ConvBCD_i into slot[index], set Done_o[index] for one cycle, set pointer = index+1 mod REQUESTERS, go to IDLE.
- Result visibility: the new slot value and Done_o appear together in the cycle after ConvDone_i.
- Latency: a request at cycle t sets Pending at t+1; IDLE grants at t+1; ConvStart_o is high at t+2. Done_o follows the converter latency plus 1.
- Simultaneous request and clear on the same index (new request during its grant cycle): set wins, so the client is converted again later. Needed because the value may have changed after sampling.
- A request for the client currently in START or WAIT sets Pending normally.
- Only one conversion is outstanding at a time. Done_o is one-hot or zero.
- Untouched slots hold their value indefinitely.
- Fairness: with all clients requesting continuously, the service order is 0,1,2,3,0,...
- ConvDone_i outside WAIT is ignored.

Optional Feature:
- Macro: BCD_SCHEDULER_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT. If TIMEOUT_CYCLES elapse without ConvDone_i, abandon the conversion and return to IDLE.
  - On abandon: an extra output port Timeout_o (1 bit) pulses for one cycle, the slot is unchanged, Done_o is not asserted, Pending is not restored, and the pointer still advances.
- Without the macro: the Timeout_o port is absent and WAIT waits indefinitely.

Decomposition:
- Shared package: FSM state encodings (IDLE/START/WAIT), the 4-bit BCD digit width constant, and a clog2-derived index-width function.
- One sub-module: rr_arbiter (request vector + pointer -> one-hot grant + index, combinational). It is reusable for other shared resources.

Test Plan:
- Single request: Binary_i[0]=1234, pulse Request_i[0] -> one ConvStart_o pulse with ConvBinary_o=1234; after the converter's Done, BCD slot 0 = 16'h1234 and Done_o = 4'b0001 for one cycle.
- All four request in the same cycle with values 1, 22, 333, 9999 -> conversions in order 0,1,2,3. Slots = 0001, 0022, 0333, 9999; each Done_o bit pulses exactly once.
- Client 2 requests twice while pending -> exactly one conversion. Client 2 re-requests during its own START -> a second conversion using the updated value 4321.
- Reset asserted in WAIT -> outputs, slots and Pending are 0 immediately. After release, a request for client 1 converts normally.
- Continuous requests on clients 0 and 3 -> alternating grants 0,3,0,3, with no starvation.
- With the timeout macro: converter stub never returns Done -> Timeout_o pulses TIMEOUT_CYCLES after START, slot unchanged, FSM back in IDLE and serving the next pending client.
